ama_pipe_adder: RTL and testbench

//  Parametrised, pipelined successor to the fixed 28-bit / 7-approximate-bit AMA adder.

---
 rtl/ama_pipe_adder.sv | 107 ++++++++++
 tb/tb_ama_pipe_adder.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/ama_pipe_adder.sv
// Pipelined approximate-mirror adder: WIDTH/SEG carry-registered stages, per-beat count of approximate LSB cells.
// Latency STAGES cycles; the whole pipe stalls while a result is held unaccepted. Optional AMA_ERR_MON_EN adds an exact-sum mismatch counter.
module ama_pipe_adder #(
    parameter int WIDTH    = 28,
    parameter int SEG      = 4,
    parameter int MAX_APPR = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           a,
    input  logic [WIDTH-1:0]           b,
    input  logic                       cin,
    input  logic [$clog2(WIDTH+1)-1:0] appr_n,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           s,
    output logic                       cout,
    output logic [31:0]                err_cnt,
    input  logic                       err_clr
);
    localparam int STAGES = WIDTH / SEG;
    localparam int NW     = $clog2(WIDTH + 1);
    localparam logic [NW-1:0] NMAX = NW'(MAX_APPR);

    // One pipeline level: the beat's operands, the sum bits resolved so far,
    // the carry into the next unresolved segment and its approximate-cell count.
    typedef struct packed {
        logic             vld;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] s;
        logic             c;
        logic [NW-1:0]    n;
`ifdef AMA_ERR_MON_EN
        logic [WIDTH:0]   ex;
`endif
    } lvl_t;

    lvl_t lv [0:STAGES];
    lvl_t nx [0:STAGES];
    logic en;

    assign en        = ~(lv[STAGES].vld & ~out_ready);
    assign in_ready  = en;
    assign out_valid = lv[STAGES].vld;
    assign s         = lv[STAGES].s;
    assign cout      = lv[STAGES].c;

    always_comb begin
        logic c;
        int   i;
        c = 1'b0;
        i = 0;
        nx[0]     = '0;
        nx[0].vld = in_valid;
        nx[0].a   = a;
        nx[0].b   = b;
        nx[0].c   = cin;
        nx[0].n   = (appr_n > NMAX) ? NMAX : appr_n;
`ifdef AMA_ERR_MON_EN
        nx[0].ex  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
`endif
        for (int k = 0; k < STAGES; k++) begin
            nx[k+1] = lv[k];
            c = lv[k].c;
            for (int j = 0; j < SEG; j++) begin
                i = k * SEG + j;
                if (i < int'(lv[k].n)) begin
                    nx[k+1].s[i] = (lv[k].a[i] & lv[k].b[i] & c) |
                                   (~lv[k].a[i] & (lv[k].b[i] | ~c));
                    c = lv[k].a[i];
                end else begin
                    nx[k+1].s[i] = lv[k].a[i] ^ lv[k].b[i] ^ c;
                    c = (lv[k].a[i] & lv[k].b[i]) | (c & (lv[k].a[i] ^ lv[k].b[i]));
                end
            end
            nx[k+1].c = c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k <= STAGES; k++) lv[k] <= '0;
        end else if (en) begin
            for (int k = 0; k <= STAGES; k++) lv[k] <= nx[k];
        end
    end

`ifdef AMA_ERR_MON_EN
    logic [31:0] cnt;
    always_ff @(posedge clk) begin
        if (rst || err_clr) begin
            cnt <= '0;
        end else if (lv[STAGES].vld && out_ready &&
                     ({lv[STAGES].c, lv[STAGES].s} != lv[STAGES].ex) && (cnt != 32'hFFFF_FFFF)) begin
            cnt <= cnt + 32'd1;
        end
    end
    assign err_cnt = cnt;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign err_cnt = 32'd0;
`endif
endmodule

// File: tb/tb_ama_pipe_adder.sv
// Directed bench for ama_pipe_adder: vector table, latency, backpressure and reset-flush sequences.
module tb_ama_pipe_adder;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, cin, out_valid, out_ready, cout, err_clr;
    logic [27:0] a, b, s;
    logic [4:0]  appr_n;
    logic [31:0] err_cnt;
    int          checks = 0;
    int          errors = 0;

    ama_pipe_adder dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .appr_n(appr_n),
        .out_valid(out_valid), .out_ready(out_ready), .s(s), .cout(cout),
        .err_cnt(err_cnt), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [27:0] a;
        logic [27:0] b;
        logic        cin;
        logic [4:0]  n;
        logic [27:0] es;
        logic        ec;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_beat(input vec_t v, output logic [27:0] rs, output logic rc, output int lat);
        @(posedge clk); #1;
        a = v.a; b = v.b; cin = v.cin; appr_n = v.n; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        rs = s;
        rc = cout;
    endtask

    function automatic logic [28:0] exact(input logic [27:0] x, input logic [27:0] y);
        return {1'b0, x} + {1'b0, y};
    endfunction

    vec_t        vt [9];
    logic [27:0] rs;
    logic        rc;
    int          lat;

    initial begin
        vt[0] = '{28'h0FFFFFF, 28'h0000001, 1'b0, 5'd0,  28'h1000000, 1'b0};
        vt[1] = '{28'h000007F, 28'h0000000, 1'b0, 5'd7,  28'h0000080, 1'b0};
        vt[2] = '{28'hFFFFFFF, 28'hFFFFFFF, 1'b1, 5'd0,  28'hFFFFFFF, 1'b1};
        vt[3] = '{28'h1234567, 28'h0FEDCBA, 1'b0, 5'd0,  28'h2222221, 1'b0};
        vt[4] = '{28'h00000FF, 28'h0000000, 1'b0, 5'd30, 28'h0000100, 1'b0};
        vt[5] = '{28'h0000000, 28'h0000000, 1'b0, 5'd4,  28'h000000F, 1'b0};
        vt[6] = '{28'h000000F, 28'h00000F0, 1'b1, 5'd8,  28'h00000F0, 1'b0};
        vt[7] = '{28'h8000000, 28'h8000000, 1'b0, 5'd0,  28'h0000000, 1'b1};
        vt[8] = '{28'hFFFFFFF, 28'h0000000, 1'b0, 5'd28, 28'h0000000, 1'b1};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; err_clr = 1'b0;
        a = '0; b = '0; cin = 1'b0; appr_n = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_s", 64'(s), 64'd0);
        check("reset_cout", 64'(cout), 64'd0);
        check("reset_err_cnt", 64'(err_cnt), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);

        for (int i = 0; i < 9; i++) begin
            run_beat(vt[i], rs, rc, lat);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'd7);
            check($sformatf("vec%0d_s", i), 64'(rs), 64'(vt[i].es));
            check($sformatf("vec%0d_cout", i), 64'(rc), 64'(vt[i].ec));
        end
        @(posedge clk); #1;
`ifdef AMA_ERR_MON_EN
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        check("err_clr", 64'(err_cnt), 64'd0);
        run_beat(vt[1], rs, rc, lat);
        @(posedge clk); #1;
        check("err_cnt_approx", 64'(err_cnt), 64'd1);
`else
        check("err_cnt_tied", 64'(err_cnt), 64'd0);
`endif

        // Ten back-to-back beats with a 4-cycle output stall after the third result.
        begin
            int sent = 0, got = 0, stall = 0, cyc = 0, stall_seen = 0;
            logic [27:0] xa, xb;
            logic [28:0] e;
            logic        acc;
            while (got < 10 && cyc < 200) begin
                @(posedge clk); #1;
                cyc++;
                in_valid = (sent < 10);
                a = 28'h0123457 * sent + 28'd1;
                b = 28'hFFFFFFF - 28'(sent * 3);
                cin = 1'b0; appr_n = 5'd0;
                out_ready = (stall == 0);
                @(negedge clk);
                acc = in_valid && in_ready;
                if (out_valid && out_ready) begin
                    xa = 28'h0123457 * got + 28'd1;
                    xb = 28'hFFFFFFF - 28'(got * 3);
                    e = exact(xa, xb);
                    check($sformatf("burst%0d_s", got), 64'(s), 64'(e[27:0]));
                    check($sformatf("burst%0d_cout", got), 64'(cout), 64'(e[28]));
                    got++;
                    if (got == 3) stall = 4;
                end else if (out_valid && !out_ready) begin
                    check("stall_in_ready", 64'(in_ready), 64'd0);
                    stall--;
                    stall_seen++;
                end
                if (acc) sent++;
            end
            check("burst_count", 64'(got), 64'd10);
            check("burst_stall_cycles", 64'(stall_seen), 64'd4);
            @(posedge clk); #1;
            in_valid = 1'b0; out_ready = 1'b1;
            got = 0;
            repeat (12) begin
                @(negedge clk);
                if (out_valid) got++;
            end
            check("burst_no_duplicate", 64'(got), 64'd0);
        end

        // Reset with five beats in flight flushes them.
        begin
            int seen = 0;
            for (int i = 0; i < 5; i++) begin
                @(posedge clk); #1;
                in_valid = 1'b1; a = 28'(i + 1); b = 28'd5; appr_n = 5'd0;
            end
            @(posedge clk); #1;
            in_valid = 1'b0; rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            check("flush_out_valid", 64'(out_valid), 64'd0);
            check("flush_in_ready", 64'(in_ready), 64'd1);
            repeat (15) begin
                @(negedge clk);
                if (out_valid) seen++;
            end
            check("flush_no_stale", 64'(seen), 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
